// File: rtl/parity_arbiter_pkg.sv
// Shared definitions for the parity-checking round-robin arbiter:
// FSM state encoding, channel/frame geometry and small index helpers.
package parity_arbiter_pkg;

    localparam int NUM_CH        = 4;
    localparam int FRAME_W       = 6;
    localparam int ERR_TOTAL_MAX = 255;

    // Two-bit FSM encoding; 2'd3 is unused and recovers to IDLE.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    typedef logic [FRAME_W-1:0] frame_t;

    // Encode a one-hot channel vector into its index (zero vector -> 0).
    function automatic logic [1:0] onehot_to_idx(input logic [NUM_CH-1:0] oh);
        return {oh[3] | oh[2], oh[3] | oh[1]};
    endfunction

    // Decode a channel index into a one-hot vector.
    function automatic logic [NUM_CH-1:0] idx_to_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/parity_arbiter_rr_arbiter4.sv
// Four-way round-robin arbiter: searches req starting at ptr and returns
// the first requesting channel as a one-hot vector (zero when idle).
module rr_arbiter4
    import parity_arbiter_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [1:0]        ptr,
    output logic [NUM_CH-1:0] winner
);

    logic [1:0] idx;
    logic       found;

    // Rotating priority scan: ptr, ptr+1, ptr+2, ptr+3 (mod 4).
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = ptr;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parity_arbiter.sv
// Round-robin arbiter over four sensor channels that grants one frame at a
// time, checks its even parity, tracks consecutive errors per channel and
// counts bad frames overall.
// Build option: define PARITY_ALARM_STICKY_EN to make alarms clear only on
// alarm_clr; otherwise an alarm also drops on the channel's next good frame.
module parity_arbiter
    import parity_arbiter_pkg::*;
#(
    parameter int ERR_THRESH = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         req,
    input  logic [NUM_CH*FRAME_W-1:0] data_in,
    input  logic [NUM_CH-1:0]         alarm_clr,
    output logic [NUM_CH-1:0]         gnt,
    output logic                      out_valid,
    output logic [1:0]                out_src,
    output logic [FRAME_W-1:0]        out_data,
    output logic                      out_err,
    output logic [NUM_CH-1:0]         alarm,
    output logic [7:0]                err_total
);

    localparam logic [1:0] THRESH_C  = 2'(ERR_THRESH);
    localparam logic [1:0] THRESH_M1 = 2'(ERR_THRESH - 1);

    logic [1:0]              state_q, state_d;
    logic [1:0]              ptr_q, ptr_d;
    logic [1:0]              winner_q, winner_d;
    logic [1:0]              src_q, src_d;
    frame_t                  frame_q, frame_d;
    logic [NUM_CH-1:0][1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0]       alarm_q, alarm_d;
    logic [7:0]              err_total_q, err_total_d;

    logic [NUM_CH-1:0]         arb_winner;
    logic [NUM_CH-1:0][FRAME_W-1:0] frames;
    logic [NUM_CH-1:0]         hit, set_alarm, clr_alarm;

    assign frames = data_in;

    rr_arbiter4 u_rr (
        .req    (req),
        .ptr    (ptr_q),
        .winner (arb_winner)
    );

    // Output decode: grant and result strobe are pure functions of state.
    always_comb begin
        gnt       = (state_q == ST_GRANT) ? idx_to_onehot(winner_q) : '0;
        out_valid = (state_q == ST_CHECK);
        out_err   = out_valid & (^frame_q);
        out_src   = src_q;
        out_data  = frame_q;
        alarm     = alarm_q;
        err_total = err_total_q;
    end

    // Transfer FSM: arbitrate in IDLE, capture the frame leaving GRANT.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        winner_d = winner_q;
        src_d    = src_q;
        frame_d  = frame_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d  = ST_GRANT;
                    winner_d = onehot_to_idx(arb_winner);
                    ptr_d    = onehot_to_idx(arb_winner) + 2'd1;
                end
            end
            ST_GRANT: begin
                state_d = ST_CHECK;
                frame_d = frames[winner_q];
                src_d   = winner_q;
            end
            ST_CHECK: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Error bookkeeping: per-channel streak counters, alarms, global total.
    always_comb begin
        cnt_d       = cnt_q;
        alarm_d     = alarm_q;
        hit         = '0;
        set_alarm   = '0;
        clr_alarm   = '0;
        err_total_d = err_total_q;
        if (out_err && (err_total_q != 8'(ERR_TOTAL_MAX)))
            err_total_d = err_total_q + 8'd1;
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i] = out_valid && (src_q == 2'(i));
            if (hit[i]) begin
                if (out_err) begin
                    if (cnt_q[i] != THRESH_C)
                        cnt_d[i] = cnt_q[i] + 2'd1;
                    // This error brings (or keeps) the streak at threshold.
                    set_alarm[i] = (cnt_q[i] >= THRESH_M1);
                end else begin
                    cnt_d[i] = 2'd0;
                end
            end
            if (alarm_clr[i])
                cnt_d[i] = 2'd0;
`ifdef PARITY_ALARM_STICKY_EN
            clr_alarm[i] = alarm_clr[i];
`else
            clr_alarm[i] = alarm_clr[i] | (hit[i] & ~out_err);
`endif
            // Set has priority over any clear in the same cycle.
            if (set_alarm[i])
                alarm_d[i] = 1'b1;
            else if (clr_alarm[i])
                alarm_d[i] = 1'b0;
        end
    end

    // State registers; reset leaves channel 0 with top priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 2'd0;
            winner_q    <= 2'd0;
            src_q       <= 2'd0;
            frame_q     <= '0;
            cnt_q       <= '0;
            alarm_q     <= '0;
            err_total_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            winner_q    <= winner_d;
            src_q       <= src_d;
            frame_q     <= frame_d;
            cnt_q       <= cnt_d;
            alarm_q     <= alarm_d;
            err_total_q <= err_total_d;
        end
    end

endmodule

// File: tb/tb_parity_arbiter.sv
// Directed bench for parity_arbiter: hand-computed frames and expected
// grants, parity results, alarms and error totals.
// Build option: PARITY_ALARM_STICKY_EN selects the sticky-alarm expectations.
module tb_parity_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [23:0] data_in = '0;
    logic [3:0]  alarm_clr = '0;
    logic [3:0]  gnt;
    logic        out_valid;
    logic [1:0]  out_src;
    logic [5:0]  out_data;
    logic        out_err;
    logic [3:0]  alarm;
    logic [7:0]  err_total;

    int n_checks = 0;
    int n_fail   = 0;

    parity_arbiter #(.ERR_THRESH(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   (data_in),
        .alarm_clr (alarm_clr),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_src   (out_src),
        .out_data  (out_data),
        .out_err   (out_err),
        .alarm     (alarm),
        .err_total (err_total)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Place a 6-bit frame into channel ch's slot of data_in.
    function automatic logic [23:0] mk(input int ch, input logic [5:0] f);
        logic [23:0] v;
        v = '0;
        v[6*ch +: 6] = f;
        return v;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        alarm_clr = '0;
        data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One full transfer from IDLE: request, grant cycle, check cycle, back to IDLE.
    task automatic send(input logic [3:0] r, input logic [23:0] d, input logic [3:0] exp_gnt,
                        input logic [1:0] exp_src, input logic [5:0] exp_data, input logic exp_err,
                        input logic hold, input logic [3:0] clr);
        req = r;
        data_in = d;
        @(posedge clk); #1;
        check_eq("gnt", gnt, exp_gnt);
        check_eq("valid_in_grant", out_valid, 0);
        if (!hold) req = '0;
        @(posedge clk); #1;
        check_eq("out_valid", out_valid, 1);
        check_eq("out_src", out_src, exp_src);
        check_eq("out_data", out_data, exp_data);
        check_eq("out_err", out_err, exp_err);
        check_eq("gnt_in_check", gnt, 0);
        alarm_clr = clr;
        @(posedge clk); #1;
        alarm_clr = '0;
        check_eq("valid_after", out_valid, 0);
        check_eq("err_after", out_err, 0);
        check_eq("data_hold", out_data, exp_data);
        check_eq("src_hold", out_src, exp_src);
    endtask

    initial begin
        do_reset();

        // Reset values
        check_eq("rst_gnt", gnt, 0);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_err", out_err, 0);
        check_eq("rst_src", out_src, 0);
        check_eq("rst_data", out_data, 0);
        check_eq("rst_alarm", alarm, 0);
        check_eq("rst_total", err_total, 0);

        // Single good frame on channel 0
        send(4'b0001, mk(0, 6'b000011), 4'b0001, 2'd0, 6'b000011, 1'b0, 1'b0, 4'b0000);
        check_eq("total_after_good", err_total, 0);

        // All four requesting, held: rotation 0,1,2,3,0
        do_reset();
        data_in = mk(0, 6'b000011) | mk(1, 6'b000111) | mk(2, 6'b101000) | mk(3, 6'b111111);
        send(4'b1111, data_in, 4'b0001, 2'd0, 6'b000011, 1'b0, 1'b1, 4'b0000);
        send(4'b1111, data_in, 4'b0010, 2'd1, 6'b000111, 1'b1, 1'b1, 4'b0000);
        send(4'b1111, data_in, 4'b0100, 2'd2, 6'b101000, 1'b0, 1'b1, 4'b0000);
        send(4'b1111, data_in, 4'b1000, 2'd3, 6'b111111, 1'b0, 1'b1, 4'b0000);
        send(4'b1111, data_in, 4'b0001, 2'd0, 6'b000011, 1'b0, 1'b0, 4'b0000);
        check_eq("rr_total", err_total, 1);
        check_eq("rr_alarm", alarm, 0);

        // Channel 2 three consecutive errors then a good frame
        do_reset();
        send(4'b0100, mk(2, 6'b000001), 4'b0100, 2'd2, 6'b000001, 1'b1, 1'b0, 4'b0000);
        check_eq("alarm2_e1", alarm, 4'b0000);
        send(4'b0100, mk(2, 6'b000001), 4'b0100, 2'd2, 6'b000001, 1'b1, 1'b0, 4'b0000);
        check_eq("alarm2_e2", alarm, 4'b0000);
        send(4'b0100, mk(2, 6'b000001), 4'b0100, 2'd2, 6'b000001, 1'b1, 1'b0, 4'b0000);
        check_eq("alarm2_e3", alarm, 4'b0100);
        check_eq("total_3", err_total, 3);
        send(4'b0100, mk(2, 6'b000000), 4'b0100, 2'd2, 6'b000000, 1'b0, 1'b0, 4'b0000);
`ifdef PARITY_ALARM_STICKY_EN
        check_eq("alarm2_sticky", alarm, 4'b0100);
        alarm_clr = 4'b0100;
        @(posedge clk); #1;
        alarm_clr = '0;
        check_eq("alarm2_clr", alarm, 4'b0000);
`else
        check_eq("alarm2_good_clr", alarm, 4'b0000);
`endif

        // Channel 1: clear pulse coincides with third error, set wins
        do_reset();
        send(4'b0010, mk(1, 6'b000001), 4'b0010, 2'd1, 6'b000001, 1'b1, 1'b0, 4'b0000);
        send(4'b0010, mk(1, 6'b000001), 4'b0010, 2'd1, 6'b000001, 1'b1, 1'b0, 4'b0000);
        check_eq("alarm1_e2", alarm, 4'b0000);
        send(4'b0010, mk(1, 6'b000001), 4'b0010, 2'd1, 6'b000001, 1'b1, 1'b0, 4'b0010);
        check_eq("alarm1_set_wins", alarm, 4'b0010);
        repeat (2) @(posedge clk);
        #1;
        check_eq("alarm1_holds", alarm, 4'b0010);
        alarm_clr = 4'b0010;
        @(posedge clk); #1;
        alarm_clr = '0;
        check_eq("alarm1_cleared", alarm, 4'b0000);
        // Counter was cleared by the clear pulse: one more error stays below threshold
        send(4'b0010, mk(1, 6'b000001), 4'b0010, 2'd1, 6'b000001, 1'b1, 1'b0, 4'b0000);
        check_eq("alarm1_cnt_cleared", alarm, 4'b0000);

        // 260 bad frames on channel 3: total saturates at 255
        do_reset();
        for (int n = 1; n <= 260; n++) begin
            send(4'b1000, mk(3, 6'b000001), 4'b1000, 2'd3, 6'b000001, 1'b1, 1'b0, 4'b0000);
            if (n == 254) check_eq("total_254", err_total, 254);
            if (n == 255) check_eq("total_255", err_total, 255);
        end
        check_eq("total_sat", err_total, 255);
        check_eq("alarm3_sat", alarm, 4'b1000);

        // Reset asserted during GRANT abandons the frame
        req = 4'b0100;
        data_in = mk(2, 6'b000011);
        @(posedge clk); #1;
        check_eq("gnt_pre_rst", gnt, 4'b0100);
        rst_n = 1'b0;
        req = '0;
        #1;
        check_eq("mid_rst_gnt", gnt, 0);
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_err", out_err, 0);
        check_eq("mid_rst_src", out_src, 0);
        check_eq("mid_rst_data", out_data, 0);
        check_eq("mid_rst_alarm", alarm, 0);
        check_eq("mid_rst_total", err_total, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check_eq("rst_no_valid", out_valid, 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_idle_valid", out_valid, 0);
        send(4'b0100, mk(2, 6'b010110), 4'b0100, 2'd2, 6'b010110, 1'b1, 1'b0, 4'b0000);
        check_eq("post_rst_total", err_total, 1);
        // Pointer now at 3: ch3 beats ch1
        send(4'b1010, mk(1, 6'b000011) | mk(3, 6'b101000), 4'b1000, 2'd3, 6'b101000, 1'b0, 1'b0, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
